seg7_frame_ctrl: RTL and testbench



---
 rtl/seg7_pkg.sv | 31 +++
 rtl/bin2bcd_serial.sv | 61 ++++++
 rtl/seg7_frame_ctrl.sv | 131 +++++++++++++
 tb/tb_seg7_frame_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment frame controller and the
// VGA sync generator it sits beside.
package seg7_pkg;

  localparam int VACT_LINES = 480;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    HOLD
  } state_e;

  // Index is the decimal digit; bit0 = segment a ... bit6 = segment g.
  localparam logic [6:0] SEG_PAT [0:9] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
    7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
  };

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    if (d <= 4'd9) return SEG_PAT[d];
    return 7'b0000000;
  endfunction

  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Serial shift-add-3 binary to BCD converter: one input bit per cycle,
// VAL_W cycles per conversion, done asserted during the final shift cycle.
module bin2bcd_serial #(
  parameter int VAL_W = 10,
  parameter int NDIG  = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [VAL_W-1:0]    bin,
  output logic                done,
  output logic [NDIG*4-1:0]   bcd
);

  localparam int CNT_W = $clog2(VAL_W + 1);

  logic [VAL_W-1:0]  bin_q, bin_d;
  logic [NDIG*4-1:0] bcd_q, bcd_d;
  logic [NDIG*4-1:0] bcd_adj;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NDIG; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
    end

    bin_d = bin_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    if (start) begin
      bin_d = bin;
      bcd_d = '0;
      cnt_d = CNT_W'(VAL_W);
    end else if (cnt_q != '0) begin
      bcd_d = {bcd_adj[NDIG*4-2:0], bin_q[VAL_W-1]};
      bin_d = {bin_q[VAL_W-2:0], 1'b0};
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample
  // their pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == CNT_W'(1));
  assign bcd  = bcd_q;

endmodule

// File: rtl/seg7_frame_ctrl.sv
// Multi-digit seven-segment controller: serial BCD conversion, vblank-aligned
// double buffer and per-column digit select. SEG7_LZB_EN adds leading-zero blanking.
module seg7_frame_ctrl
  import seg7_pkg::*;
#(
  parameter int NDIG  = 3,
  parameter int VAL_W = 10,
  parameter int X0    = 200,
  parameter int Y0    = 100,
  parameter int PITCH = 60,
  parameter int VACT  = VACT_LINES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [VAL_W-1:0] val,
  input  logic             val_valid,
  output logic             val_ready,
  input  logic [9:0]       hc,
  input  logic [9:0]       vc,
  output logic [9:0]       dig_x,
  output logic [9:0]       dig_y,
  output logic [6:0]       dig_num,
  output logic             busy,
  output logic             commit,
  output logic             ovf
);

  localparam int MAXV = pow10(NDIG) - 1;

  state_e             state_q, state_d;
  logic [9:0]         vc_q;
  logic               ovf_q, ovf_d;
  logic [NDIG*4-1:0]  disp_q, disp_d;
  logic [NDIG*4-1:0]  shadow;
  logic [VAL_W-1:0]   val_sat;
  logic               val_big;
  logic               start;
  logic               conv_done;
  logic               vblank_start;

  assign vblank_start = (vc_q != 10'(VACT)) && (vc == 10'(VACT));
  assign val_big      = int'(val) > MAXV;
  assign val_sat      = val_big ? VAL_W'(MAXV) : val;

  bin2bcd_serial #(.VAL_W(VAL_W), .NDIG(NDIG)) u_bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (val_sat),
    .done  (conv_done),
    .bcd   (shadow)
  );

  always_comb begin
    state_d = state_q;
    ovf_d   = ovf_q;
    disp_d  = disp_q;
    start   = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: if (val_valid) begin
        start   = 1'b1;
        ovf_d   = val_big;
        state_d = CONV;
      end
      CONV: if (conv_done) state_d = HOLD;
      HOLD: if (vblank_start) begin
        commit  = 1'b1;
        disp_d  = shadow;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef SEG7_LZB_EN
  logic [NDIG-1:0] blank_q, blank_d, lead_blank;
  logic            lz_run;

  // Blank flags follow the shadow digits so they land with the same commit.
  always_comb begin
    lead_blank = '0;
    lz_run     = 1'b1;
    for (int i = NDIG - 1; i >= 1; i--) begin
      lz_run        = lz_run && (shadow[i*4 +: 4] == 4'd0);
      lead_blank[i] = lz_run;
    end
    blank_d = commit ? lead_blank : blank_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) blank_q <= '0;
    else        blank_q <= blank_d;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vc_q    <= '0;
      ovf_q   <= 1'b0;
      disp_q  <= '0;
    end else begin
      state_q <= state_d;
      vc_q    <= vc;
      ovf_q   <= ovf_d;
      disp_q  <= disp_d;
    end
  end

  // Position 0 is leftmost and shows the most significant digit.
  always_comb begin
    dig_x   = 10'(X0);
    dig_num = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (int'(hc) >= X0 + i * PITCH && int'(hc) < X0 + (i + 1) * PITCH) begin
        dig_x   = 10'(X0 + i * PITCH);
        dig_num = seg_decode(disp_q[(NDIG-1-i)*4 +: 4]);
`ifdef SEG7_LZB_EN
        if (blank_q[NDIG-1-i]) dig_num = '0;
`endif
      end
    end
  end

  assign dig_y     = 10'(Y0);
  assign val_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_seg7_frame_ctrl.sv
// Self-checking bench for seg7_frame_ctrl: table vectors, corner sequences and
// randomized values against a decimal-arithmetic model of the display.
module tb_seg7_frame_ctrl;

  localparam int NDIG  = 3;
  localparam int VAL_W = 10;
  localparam int X0    = 200;
  localparam int Y0    = 100;
  localparam int PITCH = 60;
  localparam int MAXV  = 999;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [VAL_W-1:0] val;
  logic             val_valid;
  logic             val_ready;
  logic [9:0]       hc, vc;
  logic [9:0]       dig_x, dig_y;
  logic [6:0]       dig_num;
  logic             busy, commit, ovf;

  always #5 clk = ~clk;

  seg7_frame_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .val       (val),
    .val_valid (val_valid),
    .val_ready (val_ready),
    .hc        (hc),
    .vc        (vc),
    .dig_x     (dig_x),
    .dig_y     (dig_y),
    .dig_num   (dig_num),
    .busy      (busy),
    .commit    (commit),
    .ovf       (ovf)
  );

  typedef struct {
    logic [9:0] hc;
    int         pos;
  } sel_vec_t;

  typedef struct {
    logic [9:0] v;
    int         exp_ovf;
    int         exp_shown;
  } val_vec_t;

  int         n_checks = 0;
  int         n_errors = 0;
  int         shown;
  logic [6:0] pat [10];
  sel_vec_t   sel_tbl [13];
  val_vec_t   val_tbl [8];

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Pattern for digit k (0 = least significant) of a committed decimal value.
  function automatic int exp_pattern(input int value, input int k);
    int d;
    d = (value / (10 ** k)) % 10;
`ifdef SEG7_LZB_EN
    if (k > 0 && value < 10 ** k) return 0;
`endif
    return int'(pat[d]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_disp(input string tag);
    int pos;
    for (int j = 0; j < 13; j++) begin
      hc  = sel_tbl[j].hc;
      pos = sel_tbl[j].pos;
      #1;
      if (pos < 0) begin
        check($sformatf("%s_x_hc%0d", tag, hc), int'(dig_x), X0);
        check($sformatf("%s_num_hc%0d", tag, hc), int'(dig_num), 0);
      end else begin
        check($sformatf("%s_x_hc%0d", tag, hc), int'(dig_x), X0 + pos * PITCH);
        check($sformatf("%s_num_hc%0d", tag, hc), int'(dig_num),
              exp_pattern(shown, NDIG - 1 - pos));
      end
    end
    check({tag, "_dig_y"}, int'(dig_y), Y0);
  endtask

  task automatic accept(input logic [VAL_W-1:0] v);
    val       = v;
    val_valid = 1'b1;
    #1;
    check("ready_before_accept", int'(val_ready), 1);
    tick();
    val_valid = 1'b0;
  endtask

  task automatic pulse_vblank();
    vc = 10'd479;
    tick();
    vc = 10'd480;
    #1;
    check("commit_at_vblank", int'(commit), 1);
    tick();
    check("commit_one_cycle", int'(commit), 0);
    check("busy_after_commit", int'(busy), 0);
    check("ready_after_commit", int'(val_ready), 1);
    vc = 10'd100;
  endtask

  task automatic run_value(input logic [VAL_W-1:0] v, input int exp_ovf,
                           input int exp_shown, input int hold_cycles);
    vc = 10'd100;
    accept(v);
    check("busy_after_accept", int'(busy), 1);
    check("ready_in_conv", int'(val_ready), 0);
    check("ovf_after_accept", int'(ovf), exp_ovf);
    repeat (VAL_W + hold_cycles) tick();
    check("no_commit_before_vblank", int'(commit), 0);
    check("busy_in_hold", int'(busy), 1);
    pulse_vblank();
    shown = exp_shown;
    check_disp($sformatf("val%0d", v));
  endtask

  initial begin
    pat = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
            7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};
    sel_tbl = '{
      '{10'd200, 0}, '{10'd205, 0}, '{10'd259, 0},
      '{10'd260, 1}, '{10'd265, 1}, '{10'd319, 1},
      '{10'd320, 2}, '{10'd325, 2}, '{10'd379, 2},
      '{10'd380, -1}, '{10'd199, -1}, '{10'd0, -1}, '{10'd1023, -1}
    };
    val_tbl = '{
      '{10'd123, 0, 123}, '{10'd1023, 1, 999}, '{10'd5, 0, 5},
      '{10'd999, 0, 999}, '{10'd1000, 1, 999}, '{10'd0, 0, 0},
      '{10'd10, 0, 10},   '{10'd100, 0, 100}
    };

    rst_n     = 1'b0;
    val       = '0;
    val_valid = 1'b0;
    hc        = '0;
    vc        = 10'd100;
    shown     = 0;
    repeat (3) tick();
    check("rst_ready", int'(val_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_commit", int'(commit), 0);
    check("rst_ovf", int'(ovf), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_disp("reset");

    for (int i = 0; i < 8; i++)
      run_value(val_tbl[i].v, val_tbl[i].exp_ovf, val_tbl[i].exp_shown, 2);

    // vblank-start on the last conversion cycle must be skipped
    vc = 10'd100;
    accept(10'd321);
    repeat (8) tick();
    vc = 10'd479;
    tick();
    vc = 10'd480;
    #1;
    check("late_conv_no_commit", int'(commit), 0);
    tick();
    check("late_conv_still_busy", int'(busy), 1);
    vc = 10'd100;
    tick();
    pulse_vblank();
    shown = 321;
    check_disp("late_conv");

    // vblank-start on the first HOLD cycle commits immediately
    accept(10'd456);
    repeat (9) tick();
    vc = 10'd479;
    tick();
    vc = 10'd480;
    #1;
    check("hold_entry_commit", int'(commit), 1);
    tick();
    check("hold_entry_idle", int'(busy), 0);
    vc = 10'd100;
    shown = 456;
    check_disp("hold_entry");

    // vblank-start shortly after accept at vc=478 is missed
    vc = 10'd478;
    accept(10'd77);
    vc = 10'd479;
    tick();
    vc = 10'd480;
    #1;
    check("mid_conv_no_commit", int'(commit), 0);
    repeat (12) tick();
    check("mid_conv_busy", int'(busy), 1);
    vc = 10'd100;
    check_disp("mid_conv_old");
    pulse_vblank();
    shown = 77;
    check_disp("mid_conv_new");

    // val_valid during HOLD is ignored
    accept(10'd1023);
    repeat (VAL_W + 2) tick();
    val       = 10'd42;
    val_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("ready_in_hold", int'(val_ready), 0);
    end
    check_disp("hold_ignored");
    val_valid = 1'b0;
    pulse_vblank();
    shown = 999;
    check_disp("after_ignore");
    check("ovf_sat", int'(ovf), 1);
    run_value(10'd5, 0, 5, 0);

    // reset while HOLD holds a saturated value
    accept(10'd1023);
    repeat (VAL_W + 2) tick();
    #2;
    rst_n = 1'b0;
    vc    = 10'd480;
    #1;
    check("rst_hold_ready", int'(val_ready), 1);
    check("rst_hold_busy", int'(busy), 0);
    check("rst_hold_commit", int'(commit), 0);
    check("rst_hold_ovf", int'(ovf), 0);
    shown = 0;
    check_disp("rst_hold");
    vc = 10'd100;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rst_release_ready", int'(val_ready), 1);
    run_value(10'd7, 0, 7, 1);

    for (int i = 0; i < 24; i++) begin
      int v;
      int hold;
      v    = int'($urandom_range(0, 1023));
      hold = int'($urandom_range(0, 20));
      run_value(VAL_W'(v), (v > MAXV) ? 1 : 0, (v > MAXV) ? MAXV : v, hold);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
